// File: rtl/status_led_scanner.sv
// status_led_scanner: drives LED_COUNT LEDs with a bounce/wrap/blink/solid pattern,
// stepping every period+1 clocks, with global PWM dimming on the registered output.
//
// mode_q | meaning
// BOUNCE | single lit LED sweeping up and back down
// WRAP   | single lit LED sweeping up, wrapping to LED 0
// BLINK  | all LEDs toggling on every step
// SOLID  | all LEDs on
module status_led_scanner #(
  parameter int LED_COUNT = 8,
  parameter int DIV_WIDTH = 32,
  parameter int PWM_BITS  = 4,
  parameter int POS_WIDTH = $clog2(LED_COUNT)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] period,
  input  logic [PWM_BITS-1:0]  brightness,
  output logic [LED_COUNT-1:0] leds,
  output logic [POS_WIDTH-1:0] position,
  output logic                 step_pulse
);

  typedef enum logic [1:0] {
    BOUNCE = 2'd0,
    WRAP   = 2'd1,
    BLINK  = 2'd2,
    SOLID  = 2'd3
  } mode_t;

  localparam logic [POS_WIDTH-1:0] LAST_POS = POS_WIDTH'(LED_COUNT - 1);
  localparam logic [LED_COUNT-1:0] LED0     = LED_COUNT'(1);

  logic [DIV_WIDTH-1:0] timer;
  logic                 direction;
  logic                 phase;
  logic [PWM_BITS-1:0]  pwm_cnt;
  mode_t                mode_q;

  logic                 mode_change;
  logic                 tick;
  logic                 pwm_on;
  logic [LED_COUNT-1:0] pattern;

  // A mode change restarts the interval and suppresses the tick in that cycle.
  assign mode_change = (mode != mode_q);
  assign tick        = enable && !mode_change && (timer >= period);
  assign pwm_on      = (brightness == '1) || (pwm_cnt < brightness);

  always_comb begin
    pattern = '0;
    case (mode_q)
      BOUNCE, WRAP: pattern = LED0 << position;
      BLINK:        pattern = {LED_COUNT{phase}};
      SOLID:        pattern = '1;
      default:      pattern = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer      <= '0;
      position   <= '0;
      direction  <= 1'b1;
      phase      <= 1'b0;
      pwm_cnt    <= '0;
      mode_q     <= BOUNCE;
      leds       <= LED0;
      step_pulse <= 1'b0;
    end else begin
      pwm_cnt    <= pwm_cnt + 1'b1;
      step_pulse <= tick;
      leds       <= pwm_on ? pattern : '0;
      if (mode_change) begin
        timer     <= '0;
        position  <= '0;
        direction <= 1'b1;
        phase     <= 1'b0;
        mode_q    <= mode_t'(mode);
      end else if (tick) begin
        timer <= '0;
        case (mode_q)
          BOUNCE: begin
            if (direction) begin
              if (position == LAST_POS) begin
                position  <= LAST_POS - 1'b1;
                direction <= 1'b0;
              end else begin
                position <= position + 1'b1;
              end
            end else begin
              if (position == '0) begin
                position  <= POS_WIDTH'(1);
                direction <= 1'b1;
              end else begin
                position <= position - 1'b1;
              end
            end
          end
          WRAP: begin
            position  <= (position == LAST_POS) ? '0 : position + 1'b1;
            direction <= 1'b1;
          end
          BLINK:   phase <= ~phase;
          default: ;
        endcase
      end else if (enable) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_status_led_scanner.sv
// Self-checking bench for status_led_scanner: directed sequences, a PWM vector table,
// and randomized stimulus checked every cycle against a step-count reference model.
module tb_status_led_scanner;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int PB = 4;
  localparam int PW = 3;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] period = '0;
  logic [PB-1:0] brightness = '1;
  logic [N-1:0]  leds;
  logic [PW-1:0] position;
  logic          step_pulse;

  status_led_scanner #(.LED_COUNT(N), .DIV_WIDTH(DW), .PWM_BITS(PB)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .period(period),
    .brightness(brightness), .leds(leds), .position(position), .step_pulse(step_pulse)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: the pattern is a function of the number of steps since the last mode change.
  int           m_mode;
  longint       m_timer;
  int           m_steps;
  int           m_pwm;
  logic [N-1:0] e_leds;
  int           e_pos;
  bit           e_pulse;

  typedef struct {
    logic [PB-1:0] bright;
    int            on_cnt;
  } pwm_vec_t;
  pwm_vec_t pwm_tbl[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  function automatic int ref_pos(input int md, input int k);
    int r;
    if (md == 0) begin
      r = k % (2 * (N - 1));
      return (r < N) ? r : 2 * (N - 1) - r;
    end
    if (md == 1) return k % N;
    return 0;
  endfunction

  function automatic logic [N-1:0] ref_pattern(input int md, input int k);
    logic [N-1:0] one;
    one = 1;
    if (md <= 1) return one << ref_pos(md, k);
    if (md == 2) return (k % 2 == 1) ? '1 : '0;
    return '1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_timer = 0; m_steps = 0; m_pwm = 0;
    e_leds = 1; e_pos = 0; e_pulse = 0;
  endtask

  task automatic model_edge();
    bit tick, pwm_on;
    tick   = enable && (int'(mode) == m_mode) && (m_timer >= longint'(period));
    pwm_on = (brightness == '1) || (m_pwm < int'(brightness));
    e_leds = pwm_on ? ref_pattern(m_mode, m_steps) : '0;
    if (int'(mode) != m_mode) begin
      m_mode = int'(mode); m_timer = 0; m_steps = 0;
    end else if (tick) begin
      m_timer = 0; m_steps++;
    end else if (enable) begin
      m_timer++;
    end
    e_pulse = tick;
    e_pos   = ref_pos(m_mode, m_steps);
    m_pwm   = (m_pwm + 1) % (1 << PB);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check("leds", leds, e_leds);
    check("position", position, e_pos);
    check("step_pulse", step_pulse, e_pulse);
  endtask

  // Called 1 time unit after an edge; reset lands mid-cycle.
  task automatic reset_pulse();
    reset = 1'b1;
    #1;
    check("rst_leds", leds, 8'h01);
    check("rst_position", position, 0);
    check("rst_step_pulse", step_pulse, 0);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int exp_seq[16];
    int idx, gap, n, cnt;
    logic [PW-1:0] saved_pos;
    logic [N-1:0]  saved_leds;

    pwm_tbl[0] = '{4'd0,  0};
    pwm_tbl[1] = '{4'd4,  4};
    pwm_tbl[2] = '{4'd15, 16};
    pwm_tbl[3] = '{4'd1,  1};
    pwm_tbl[4] = '{4'd8,  8};
    pwm_tbl[5] = '{4'd14, 14};
    exp_seq = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check("reset_leds", leds, 8'h01);
    check("reset_position", position, 0);
    check("reset_step_pulse", step_pulse, 0);
    reset = 1'b0;

    // Bounce, period 3: pulse every 4 clocks, first one on the 4th edge.
    mode = 2'd0; period = 3; brightness = 4'hF; enable = 1'b1;
    idx = 0; gap = 0;
    for (int i = 0; i < 200 && idx < 16; i++) begin
      step();
      gap++;
      if (step_pulse) begin
        check("bounce_pos", position, exp_seq[idx]);
        check("bounce_gap", gap, 4);
        idx++;
        gap = 0;
      end
    end
    if (idx < 16) timeout("bounce_seq");

    // Asynchronous reset mid-scan at position 5, then restart going up.
    for (int i = 0; i < 100 && position != 3'd5; i++) step();
    if (position != 3'd5) timeout("reach_pos5");
    #2;
    reset_pulse();
    n = 0;
    for (int i = 0; i < 20 && !step_pulse; i++) begin step(); n++; end
    check("restart_first_tick", n, 4);
    check("restart_pos", position, 1);

    // Wrap, period 0: steps every cycle.
    mode = 2'd1; period = 0;
    for (int i = 0; i < 30 && position != 3'd6; i++) step();
    if (position != 3'd6) timeout("reach_wrap6");
    step(); check("wrap_pos7", position, 7); check("wrap_leds40", leds, 8'h40);
    step(); check("wrap_pos0", position, 0); check("wrap_leds80", leds, 8'h80);
    step(); check("wrap_pos1", position, 1); check("wrap_leds01", leds, 8'h01);
    step(); check("wrap_leds02", leds, 8'h02);

    // Blink, period 1, then switch to bounce mid-interval.
    mode = 2'd2; period = 1;
    repeat (3) step();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (leds == 8'hFF) cnt++;
    end
    check("blink_on_count", cnt, 4);
    repeat (2) step();
    mode = 2'd0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      n++;
      if (n == 1) begin
        check("chg_no_pulse", step_pulse, 0);
        check("chg_pos0", position, 0);
      end
      if (step_pulse) break;
    end
    check("chg_next_pulse", n, 3);

    // Solid.
    mode = 2'd3;
    repeat (2) step();
    for (int i = 0; i < 6; i++) begin
      step();
      check("solid_leds", leds, 8'hFF);
    end

    // PWM duty table in solid mode.
    foreach (pwm_tbl[t]) begin
      brightness = pwm_tbl[t].bright;
      cnt = 0;
      for (int i = 0; i < 16; i++) begin
        step();
        if (leds == 8'hFF) cnt++;
      end
      check("pwm_on_count", cnt, pwm_tbl[t].on_cnt);
    end

    // Enable low for 20 clocks freezes everything.
    mode = 2'd0; period = 3; brightness = 4'hF; enable = 1'b1;
    repeat (10) step();
    enable = 1'b0;
    step();
    saved_pos = position;
    saved_leds = leds;
    for (int i = 0; i < 20; i++) begin
      step();
      check("frz_pos", position, saved_pos);
      check("frz_leds", leds, saved_leds);
      check("frz_pulse", step_pulse, 0);
    end
    enable = 1'b1;
    repeat (10) step();

    // Lowering period below the running timer ticks on the next cycle.
    period = 100;
    for (int i = 0; i < 200 && m_timer != 50; i++) step();
    if (m_timer != 50) timeout("timer_reach_50");
    period = 2;
    step();
    check("period_drop_tick", step_pulse, 1);

    // Randomized stimulus.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) reset_pulse();
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) period = DW'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) brightness = PB'($urandom_range(0, 15));
      enable = ($urandom_range(0, 7) != 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
